user_project_addr_space_regfile: RTL and testbench
==================================================

Name: user_project_addr_space_regfile

Overview:
- Parametrised successor to the single-register address-space test slave.
- Wishbone slave on the user-project bus (WB MI A) with a DEPTH-word register file at BASE_ADDR, byte-lane writes, programmable wait states, and a fixed default value for unmapped reads.
- Exports access statistics, so cocotb tests can check address decode, byte enables, stalls and aborts across the user address space.

Parameters:
- DEPTH, 16, number of 32-bit registers; power of two, 2..256; AW = log2(DEPTH).
- BASE_ADDR, 32'h3000_0000, window base; bits [AW+1:0] must be 0.
- WAIT_CYCLES, 0, extra stall cycles before ack; 0..15.
- READ_DEFAULT, 32'h0000_0777, data returned for unmapped reads.

Ports:
- wb_clk_i  in  1  clock
- wb_rst_i  in  1  asynchronous, active-high reset
- wbs_stb_i  in  1  strobe
- wbs_cyc_i  in  1  bus cycle
- wbs_we_i  in  1  1 = write
- wbs_sel_i  in  4  byte-lane enables
- wbs_dat_i  in  32  write data
- wbs_adr_i  in  32  byte address
- wbs_ack_o  out  1  registered acknowledge
- wbs_dat_o  out  32  registered read data
- access_cnt_o  out  16  saturating count of completed (acked) accesses
- last_addr_o  out  32  address of the last completed access

Behaviour:
- Reset (async, high): ack=0, dat_o=0, access_cnt_o=0, last_addr_o=0, all registers=0, FSM=IDLE; applies immediately, including mid-transaction.
- Decode: hit = (adr[31:AW+2] == BASE_ADDR[31:AW+2]); index = adr[AW+1:2]; adr[1:0] ignored.
- Request = cyc & stb & !ack.
- FSM states:
  - IDLE: on request, latch we, sel, adr, dat_i and hit. If WAIT_CYCLES=0 go to ACK, else load the counter with WAIT_CYCLES and go to WAIT.
  - WAIT: decrement the counter; when it reaches 1, go to ACK. If cyc or stb drops, go to IDLE: no ack, no register update, no count.
  - ACK: ack=1 for exactly one cycle, then IDLE. ack is 0 in every other state.
- Latency: ack rises WAIT_CYCLES+1 clocks after the request is first sampled. Back-to-back requests are separated by at least one ack-low cycle.
- Write, hit: on entering ACK, regs[index] byte k <= dat_i byte k for each sel[k]=1; lanes with sel=0 are unchanged. sel=0 acks with no change.
- Write, miss: acked, data discarded.
- Read: dat_o = regs[index] if hit, else READ_DEFAULT; valid in the ack cycle and held until the next read ack. Reads ignore sel.
- Write-then-read of the same index returns the new value (write completes before the read is sampled).
- Statistics: on each ack, access_cnt_o += 1, saturating at 16'hFFFF with no wrap; last_addr_o <= latched adr.
- Latched request fields are not re-sampled during WAIT; input changes mid-stall are ignored.

Optional Feature:
- Macro: USER_ADDR_SPACE_ERR_EN.
- Defined: adds port wbs_err_o (out, 1, reset 0). A miss completes with err=1 for one cycle instead of ack: same timing, dat_o unchanged, no write. access_cnt_o still increments and last_addr_o still updates.
- Undefined: port absent; misses ack with READ_DEFAULT / discarded write as above.

Test Plan:
- WAIT_CYCLES=0: write 32'hDEADBEEF sel=4'hF to 0x3000_0008, then read 0x3000_0008 -> ack 1 clock after each request; read returns 32'hDEADBEEF; access_cnt_o=2; last_addr_o=0x3000_0008.
- Byte lanes: write 32'h11223344 sel=4'hF, then 32'hAABBCCDD sel=4'b0101 to index 3 -> read returns 32'h11BB33DD.
- Miss: read 0x3000_1000 -> 32'h0000_0777 with ack; with USER_ADDR_SPACE_ERR_EN defined -> err=1, ack=0.
- WAIT_CYCLES=3: read index 0 -> ack exactly 4 clocks after the request; drop cyc after 2 clocks on a write -> no ack, register unchanged, count unchanged.
- Reset asserted in the ACK or WAIT state -> ack=0 immediately; registers, access_cnt_o and last_addr_o read back 0 after release.
- Preload access_cnt_o via 65535 accesses, then one more -> stays 16'hFFFF.

Source files
------------

// File: rtl/user_project_addr_space_regfile.sv
// Wishbone register-file slave: DEPTH words at BASE_ADDR, byte-lane writes, wait states, access statistics.
// Define USER_ADDR_SPACE_ERR_EN to answer misses with wbs_err_o instead of wbs_ack_o.

module user_project_addr_space_lane (
    input  logic       sel,
    input  logic [7:0] old_byte,
    input  logic [7:0] new_byte,
    output logic [7:0] merged
);
    assign merged = sel ? new_byte : old_byte;
endmodule

module user_project_addr_space_regfile #(
    parameter int unsigned DEPTH        = 16,
    parameter logic [31:0] BASE_ADDR    = 32'h3000_0000,
    parameter int unsigned WAIT_CYCLES  = 0,
    parameter logic [31:0] READ_DEFAULT = 32'h0000_0777
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_dat_i,
    input  logic [31:0] wbs_adr_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic [15:0] access_cnt_o,
    output logic [31:0] last_addr_o
`ifdef USER_ADDR_SPACE_ERR_EN
    ,
    output logic        wbs_err_o
`endif
);
    localparam int         AW        = $clog2(DEPTH);
    localparam int         NUM_LANES = 4;
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);
`ifdef USER_ADDR_SPACE_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

    typedef struct packed {
        logic        we;
        logic [3:0]  sel;
        logic [31:0] adr;
        logic [31:0] dat;
        logic        hit;
    } req_t;

    state_t                      state, state_nxt;
    req_t                        req_in, req_q, cur;
    logic [3:0]                  wait_cnt;
    logic [31:0]                 regs [DEPTH];
    logic [AW-1:0]               cur_idx;
    logic [31:0]                 cur_word;
    logic [NUM_LANES-1:0][7:0]   wr_merged;
    logic                        req, hit, bus_held, enter_ack;

    assign req      = wbs_cyc_i & wbs_stb_i & ~wbs_ack_o;
    assign bus_held = wbs_cyc_i & wbs_stb_i;
    assign hit      = (wbs_adr_i[31:AW+2] == BASE_ADDR[31:AW+2]);
    assign req_in   = '{we: wbs_we_i, sel: wbs_sel_i, adr: wbs_adr_i, dat: wbs_dat_i, hit: hit};

    // With no wait states ACK is entered straight from IDLE, before the latch holds the request.
    assign cur       = (state == S_IDLE) ? req_in : req_q;
    assign cur_idx   = cur.adr[AW+1:2];
    assign cur_word  = regs[cur_idx];
    assign enter_ack = (state_nxt == S_ACK);

    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        user_project_addr_space_lane u_lane (
            .sel      (cur.sel[l]),
            .old_byte (cur_word[8*l +: 8]),
            .new_byte (cur.dat[8*l +: 8]),
            .merged   (wr_merged[l])
        );
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) state <= S_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: if (req) state_nxt = (WAIT_CYCLES == 0) ? S_ACK : S_WAIT;
            S_WAIT: begin
                if (!bus_held)              state_nxt = S_IDLE;
                else if (wait_cnt == 4'd1)  state_nxt = S_ACK;
            end
            S_ACK:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        wbs_ack_o = 1'b0;
`ifdef USER_ADDR_SPACE_ERR_EN
        wbs_err_o = 1'b0;
        if (state == S_ACK) begin
            if (req_q.hit) wbs_ack_o = 1'b1;
            else           wbs_err_o = 1'b1;
        end
`else
        wbs_ack_o = (state == S_ACK);
`endif
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            req_q        <= '0;
            wait_cnt     <= '0;
            wbs_dat_o    <= '0;
            access_cnt_o <= '0;
            last_addr_o  <= '0;
            for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
        end else begin
            if (state == S_IDLE && req) begin
                req_q    <= req_in;
                wait_cnt <= WAIT_INIT;
            end else if (state == S_WAIT) begin
                wait_cnt <= wait_cnt - 4'd1;
            end
            if (enter_ack) begin
                if (cur.we) begin
                    if (cur.hit) regs[cur_idx] <= wr_merged;
                end else if (cur.hit) begin
                    wbs_dat_o <= cur_word;
                end else if (!ERR_EN) begin
                    wbs_dat_o <= READ_DEFAULT;
                end
                if (access_cnt_o != 16'hFFFF) access_cnt_o <= access_cnt_o + 16'd1;
                last_addr_o <= cur.adr;
            end
        end
    end
endmodule

// File: tb/tb_user_project_addr_space_regfile.sv
// Randomised bench for user_project_addr_space_regfile: one instance with no wait states, one with three.
module tb_user_project_addr_space_regfile;
    localparam int          DEPTH = 16;
    localparam logic [31:0] BASE  = 32'h3000_0000;
    localparam logic [31:0] RDEF  = 32'h0000_0777;
`ifdef USER_ADDR_SPACE_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic        clk = 1'b0, rst = 1'b1;
    logic        cyc [2], stb [2], we [2], ack [2], err [2];
    logic [3:0]  sel [2];
    logic [31:0] dat_i [2], adr [2], dat_o [2], last [2];
    logic [15:0] cnt [2];

    int n_tests = 0, n_fail = 0;

    bit [31:0]   mreg [2][DEPTH];
    int unsigned mcnt [2];
    bit [31:0]   mlast [2], mdat [2];

    always #5 clk = ~clk;

    user_project_addr_space_regfile #(.WAIT_CYCLES(0)) dut0 (
        .wb_clk_i(clk), .wb_rst_i(rst), .wbs_stb_i(stb[0]), .wbs_cyc_i(cyc[0]),
        .wbs_we_i(we[0]), .wbs_sel_i(sel[0]), .wbs_dat_i(dat_i[0]), .wbs_adr_i(adr[0]),
        .wbs_ack_o(ack[0]), .wbs_dat_o(dat_o[0]), .access_cnt_o(cnt[0]), .last_addr_o(last[0])
`ifdef USER_ADDR_SPACE_ERR_EN
        , .wbs_err_o(err[0])
`endif
    );

    user_project_addr_space_regfile #(.WAIT_CYCLES(3)) dut3 (
        .wb_clk_i(clk), .wb_rst_i(rst), .wbs_stb_i(stb[1]), .wbs_cyc_i(cyc[1]),
        .wbs_we_i(we[1]), .wbs_sel_i(sel[1]), .wbs_dat_i(dat_i[1]), .wbs_adr_i(adr[1]),
        .wbs_ack_o(ack[1]), .wbs_dat_o(dat_o[1]), .access_cnt_o(cnt[1]), .last_addr_o(last[1])
`ifdef USER_ADDR_SPACE_ERR_EN
        , .wbs_err_o(err[1])
`endif
    );

`ifndef USER_ADDR_SPACE_ERR_EN
    assign err[0] = 1'b0;
    assign err[1] = 1'b0;
`endif

    function automatic bit m_hit(input bit [31:0] a);
        return (a / (DEPTH * 4)) == (BASE / (DEPTH * 4));
    endfunction

    function automatic int m_idx(input bit [31:0] a);
        return int'((a / 4) % DEPTH);
    endfunction

    task automatic m_reset();
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < DEPTH; i++) mreg[d][i] = 0;
            mcnt[d] = 0; mlast[d] = 0; mdat[d] = 0;
        end
    endtask

    task automatic m_apply(input int d, input bit w, input bit [31:0] a, input bit [31:0] wd, input bit [3:0] s);
        if (m_hit(a)) begin
            if (w) begin
                for (int b = 0; b < 4; b++)
                    if (s[b]) begin
                        bit [31:0] m = 32'hFF << (8 * b);
                        mreg[d][m_idx(a)] = (mreg[d][m_idx(a)] & ~m) | (wd & m);
                    end
            end else mdat[d] = mreg[d][m_idx(a)];
        end else if (!w && !ERR_EN) mdat[d] = RDEF;
        mcnt[d]  = (mcnt[d] == 65535) ? 65535 : mcnt[d] + 1;
        mlast[d] = a;
    endtask

    // One bus access; lat = clocks from the sampling edge to the first ack/err, -1 if none.
    task automatic xfer(input int d, input bit w, input bit [31:0] a, input bit [31:0] wd, input bit [3:0] s,
                        output bit [31:0] rd, output int lat, output bit got_err);
        @(negedge clk);
        cyc[d] = 1; stb[d] = 1; we[d] = w; adr[d] = a; dat_i[d] = wd; sel[d] = s;
        lat = -1; rd = 0; got_err = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (ack[d] || err[d]) begin
                lat = i; rd = dat_o[d]; got_err = err[d];
                break;
            end
        end
        cyc[d] = 0; stb[d] = 0; we[d] = 0;
        if (lat != -1) m_apply(d, w, a, wd, s);
    endtask

    task automatic test_reset();
        for (int d = 0; d < 2; d++) begin
            n_tests++; if (ack[d] !== 1'b0) begin n_fail++; $display("FAIL reset_ack[%0d] got %b want 0", d, ack[d]); end
            n_tests++; if (dat_o[d] !== 32'h0) begin n_fail++; $display("FAIL reset_dat[%0d] got %h want 0", d, dat_o[d]); end
            n_tests++; if (cnt[d] !== 16'h0) begin n_fail++; $display("FAIL reset_cnt[%0d] got %h want 0", d, cnt[d]); end
            n_tests++; if (last[d] !== 32'h0) begin n_fail++; $display("FAIL reset_last[%0d] got %h want 0", d, last[d]); end
        end
    endtask

    task automatic test_basic();
        bit [31:0] rd; int lat; bit e;
        xfer(0, 1, 32'h3000_0008, 32'hDEADBEEF, 4'hF, rd, lat, e);
        n_tests++; if (lat !== 1) begin n_fail++; $display("FAIL basic_wr_lat got %0d want 1", lat); end
        xfer(0, 0, 32'h3000_0008, 32'h0, 4'h0, rd, lat, e);
        n_tests++; if (lat !== 1) begin n_fail++; $display("FAIL basic_rd_lat got %0d want 1", lat); end
        n_tests++; if (rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL basic_rd_data got %h want deadbeef", rd); end
        n_tests++; if (cnt[0] !== 16'd2) begin n_fail++; $display("FAIL basic_cnt got %0d want 2", cnt[0]); end
        n_tests++; if (last[0] !== 32'h3000_0008) begin n_fail++; $display("FAIL basic_last got %h want 30000008", last[0]); end
    endtask

    task automatic test_byte_lanes();
        bit [31:0] rd; int lat; bit e;
        xfer(0, 1, 32'h3000_000C, 32'h11223344, 4'hF, rd, lat, e);
        xfer(0, 1, 32'h3000_000C, 32'hAABBCCDD, 4'b0101, rd, lat, e);
        xfer(0, 0, 32'h3000_000C, 32'h0, 4'h0, rd, lat, e);
        n_tests++; if (rd !== 32'h11BB33DD) begin n_fail++; $display("FAIL lanes_rd got %h want 11bb33dd", rd); end
        xfer(0, 1, 32'h3000_000E, 32'hFFFFFFFF, 4'h0, rd, lat, e);
        xfer(0, 0, 32'h3000_000D, 32'h0, 4'hF, rd, lat, e);
        n_tests++; if (rd !== 32'h11BB33DD) begin n_fail++; $display("FAIL lanes_sel0 got %h want 11bb33dd", rd); end
    endtask

    task automatic test_miss();
        bit [31:0] rd, want; int lat; bit e;
        want = ERR_EN ? mdat[0] : RDEF;
        xfer(0, 0, 32'h3000_1000, 32'h0, 4'hF, rd, lat, e);
        n_tests++; if (lat !== 1) begin n_fail++; $display("FAIL miss_lat got %0d want 1", lat); end
        n_tests++; if (rd !== want) begin n_fail++; $display("FAIL miss_data got %h want %h", rd, want); end
        n_tests++; if (e !== ERR_EN) begin n_fail++; $display("FAIL miss_err got %b want %b", e, ERR_EN); end
        n_tests++; if (last[0] !== 32'h3000_1000) begin n_fail++; $display("FAIL miss_last got %h want 30001000", last[0]); end
    endtask

    task automatic test_wait();
        bit [31:0] rd; int lat, acks; bit e;
        xfer(1, 0, 32'h3000_0000, 32'h0, 4'h0, rd, lat, e);
        n_tests++; if (lat !== 4) begin n_fail++; $display("FAIL wait_lat got %0d want 4", lat); end
        n_tests++; if (rd !== 32'h0) begin n_fail++; $display("FAIL wait_rd got %h want 0", rd); end
        xfer(1, 1, 32'h3000_0014, 32'h12345678, 4'hF, rd, lat, e);
        // Abort: drop cyc two clocks into the stall.
        @(negedge clk);
        cyc[1] = 1; stb[1] = 1; we[1] = 1; adr[1] = 32'h3000_0014; dat_i[1] = 32'hCAFEF00D; sel[1] = 4'hF;
        acks = 0;
        repeat (2) begin @(negedge clk); if (ack[1]) acks++; end
        cyc[1] = 0; stb[1] = 0;
        repeat (6) begin @(negedge clk); if (ack[1]) acks++; end
        n_tests++; if (acks !== 0) begin n_fail++; $display("FAIL abort_ack got %0d acks want 0", acks); end
        n_tests++; if (cnt[1] !== 16'(mcnt[1])) begin n_fail++; $display("FAIL abort_cnt got %0d want %0d", cnt[1], mcnt[1]); end
        xfer(1, 0, 32'h3000_0014, 32'h0, 4'h0, rd, lat, e);
        n_tests++; if (rd !== 32'h12345678) begin n_fail++; $display("FAIL abort_reg got %h want 12345678", rd); end
        // Inputs changing mid-stall must not affect the latched request.
        @(negedge clk);
        cyc[1] = 1; stb[1] = 1; we[1] = 1; adr[1] = 32'h3000_0018; dat_i[1] = 32'hA5A5_0001; sel[1] = 4'hF;
        @(negedge clk);
        adr[1] = 32'h3000_001C; dat_i[1] = 32'h5A5A_0002; sel[1] = 4'h1;
        lat = -1;
        for (int i = 2; i <= 40; i++) begin @(negedge clk); if (ack[1]) begin lat = i; break; end end
        cyc[1] = 0; stb[1] = 0; we[1] = 0;
        n_tests++; if (lat !== 4) begin n_fail++; $display("FAIL stall_lat got %0d want 4", lat); end
        if (lat != -1) m_apply(1, 1, 32'h3000_0018, 32'hA5A5_0001, 4'hF);
        n_tests++; if (last[1] !== 32'h3000_0018) begin n_fail++; $display("FAIL stall_last got %h want 30000018", last[1]); end
        xfer(1, 0, 32'h3000_0018, 32'h0, 4'h0, rd, lat, e);
        n_tests++; if (rd !== 32'hA5A5_0001) begin n_fail++; $display("FAIL stall_reg got %h want a5a50001", rd); end
    endtask

    task automatic test_back_to_back();
        bit pat [4];
        @(negedge clk);
        cyc[0] = 1; stb[0] = 1; we[0] = 0; adr[0] = 32'h3000_000C; sel[0] = 4'hF;
        for (int i = 0; i < 4; i++) begin @(negedge clk); pat[i] = ack[0]; end
        cyc[0] = 0; stb[0] = 0;
        m_apply(0, 0, 32'h3000_000C, 32'h0, 4'hF);
        m_apply(0, 0, 32'h3000_000C, 32'h0, 4'hF);
        n_tests++;
        if (pat[0] !== 1 || pat[1] !== 0 || pat[2] !== 1 || pat[3] !== 0) begin
            n_fail++; $display("FAIL b2b_pattern got %b%b%b%b want 1010", pat[0], pat[1], pat[2], pat[3]);
        end
        n_tests++; if (cnt[0] !== 16'(mcnt[0])) begin n_fail++; $display("FAIL b2b_cnt got %0d want %0d", cnt[0], mcnt[0]); end
        n_tests++; if (dat_o[0] !== mdat[0]) begin n_fail++; $display("FAIL b2b_dat got %h want %h", dat_o[0], mdat[0]); end
    endtask

    task automatic test_random();
        bit [31:0] rd, a; int lat, d; bit w, e, want_e;
        for (int n = 0; n < 60; n++) begin
            d = int'($urandom_range(1, 0));
            w = 1'($urandom_range(1, 0));
            if ($urandom_range(3, 0) != 0) a = BASE + 32'($urandom_range(DEPTH * 4 - 1, 0));
            else a = $urandom;
            want_e = ERR_EN && !m_hit(a);
            xfer(d, w, a, $urandom, 4'($urandom_range(15, 0)), rd, lat, e);
            n_tests++; if (lat !== (d == 1 ? 4 : 1)) begin n_fail++; $display("FAIL rnd_lat[%0d] d%0d got %0d", n, d, lat); end
            n_tests++; if (e !== want_e) begin n_fail++; $display("FAIL rnd_err[%0d] got %b want %b", n, e, want_e); end
            if (!w) begin
                n_tests++; if (rd !== mdat[d]) begin n_fail++; $display("FAIL rnd_rd[%0d] adr %h got %h want %h", n, a, rd, mdat[d]); end
            end
            n_tests++; if (cnt[d] !== 16'(mcnt[d])) begin n_fail++; $display("FAIL rnd_cnt[%0d] got %0d want %0d", n, cnt[d], mcnt[d]); end
            n_tests++; if (last[d] !== mlast[d]) begin n_fail++; $display("FAIL rnd_last[%0d] got %h want %h", n, last[d], mlast[d]); end
        end
    endtask

    task automatic test_reset_mid();
        bit [31:0] rd; int lat; bit e;
        @(negedge clk);
        cyc[1] = 1; stb[1] = 1; we[1] = 1; adr[1] = 32'h3000_0004; dat_i[1] = 32'h1; sel[1] = 4'hF;
        @(negedge clk);
        cyc[0] = 1; stb[0] = 1; we[0] = 1; adr[0] = 32'h3000_0004; dat_i[0] = 32'h1; sel[0] = 4'hF;
        @(negedge clk);
        n_tests++; if (ack[0] !== 1'b1) begin n_fail++; $display("FAIL rstmid_pre_ack got %b want 1", ack[0]); end
        rst = 1;
        #1;
        n_tests++; if (ack[0] !== 1'b0) begin n_fail++; $display("FAIL rstmid_ack0 got %b want 0", ack[0]); end
        n_tests++; if (ack[1] !== 1'b0) begin n_fail++; $display("FAIL rstmid_ack1 got %b want 0", ack[1]); end
        cyc[0] = 0; stb[0] = 0; cyc[1] = 0; stb[1] = 0;
        @(negedge clk); rst = 0;
        m_reset();
        for (int d = 0; d < 2; d++) begin
            n_tests++; if (cnt[d] !== 16'h0) begin n_fail++; $display("FAIL rstmid_cnt[%0d] got %0d want 0", d, cnt[d]); end
            n_tests++; if (last[d] !== 32'h0) begin n_fail++; $display("FAIL rstmid_last[%0d] got %h want 0", d, last[d]); end
            foreach (mreg[0][i]) if (i == 3 || i == 4 || i == 5) begin
                xfer(d, 0, BASE + 32'(4 * i), 32'h0, 4'hF, rd, lat, e);
                n_tests++; if (rd !== 32'h0) begin n_fail++; $display("FAIL rstmid_reg[%0d][%0d] got %h want 0", d, i, rd); end
            end
        end
    endtask

    task automatic test_saturate();
        bit [31:0] rd; int lat; bit e;
        @(negedge clk);
        force dut0.access_cnt_o = 16'hFFFD;
        #1 release dut0.access_cnt_o;
        mcnt[0] = 16'hFFFD;
        for (int i = 0; i < 3; i++) begin
            xfer(0, 0, 32'h3000_0000, 32'h0, 4'h0, rd, lat, e);
            n_tests++; if (cnt[0] !== 16'(mcnt[0])) begin n_fail++; $display("FAIL sat_cnt[%0d] got %h want %h", i, cnt[0], mcnt[0]); end
        end
        n_tests++; if (cnt[0] !== 16'hFFFF) begin n_fail++; $display("FAIL sat_final got %h want ffff", cnt[0]); end
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            cyc[d] = 0; stb[d] = 0; we[d] = 0; sel[d] = 0; dat_i[d] = 0; adr[d] = 0;
        end
        m_reset();
        repeat (3) @(negedge clk);
        test_reset();
        rst = 0;
        test_basic();
        test_byte_lanes();
        test_miss();
        test_wait();
        test_back_to_back();
        test_random();
        test_reset_mid();
        test_saturate();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end
endmodule
